uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter (trmt/tx_data/tx_done, 19200 baud) between NUM_REQ byte requesters.
//  - Arbitration is round-robin. The arbiter latches the winning byte, issues a one-cycle trmt and holds ownership until tx_done.
//  - It sits between the maze-solver's status/telemetry producers and the UART transmitter.
// PARAMETERS
//  NUM_REQ      4      number of requesters (2..8)
//  TIMEOUT_CYC  32768  BUSY watchdog limit in clk cycles; a full frame is ~26040 cycles
// PORTS
//  clk          in   1          system clock; only clock
//  rst_n        in   1          reset; synchronous, active-low
//  req          in   NUM_REQ    req[i]=1: requester i has a byte; hold with data until req_ack[i]
//  req_data     in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//  req_ack      out  NUM_REQ    one-cycle pulse; byte i accepted and latched
//  trmt         out  1          to UART trmt; one-cycle pulse
//  tx_data      out  8          to UART tx_data; stable from trmt until the next grant
//  tx_done      in   1          from UART; level, set at frame end, cleared by the UART on trmt
//  busy         out  1          1 in SEND or BUSY
//  grant_id     out  $clog2(NUM_REQ)  index of the current or last owner
//  timeout_err  out  1          one-cycle pulse on watchdog expiry (0 without macro)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, trmt=0, req_ack=0, tx_data=8'h00, busy=0,
//    grant_id=0, timeout_err=0, rr pointer last=NUM_REQ-1 (requester 0 wins first).
//    Reset mid-frame: abandon the frame, no ack/err pulse; UART shares rst_n.
//  States: IDLE -> SEND -> BUSY -> IDLE.
//  - IDLE: if |req, winner = first set bit searching last+1, last+2, ... (mod NUM_REQ).
//      At the edge: tx_data<=req_data[winner], grant_id<=winner, last<=winner,
//      trmt<=1, req_ack[winner]<=1; go to SEND. If no req, stay in IDLE.
//  - SEND: exactly one cycle. trmt=1 and req_ack pulse are visible here. The UART clears tx_done
//      at the end of this cycle. Go to BUSY; trmt<=0, req_ack<=0.
//  - BUSY: tx_done is not sampled before this state, so a stale tx_done is never treated as completion.
//      When tx_done=1, go to IDLE. A pending req is re-arbitrated in that IDLE cycle.
//  Latency: req rises in IDLE cycle k -> trmt/ack in cycle k+1 -> UART starts at end of k+1.
//      Back-to-back issue: trmt at most once per tx_done + 2 cycles.
//  - req changes while in SEND/BUSY are ignored. Deassertion of an unacked req before the grant is legal.
//  - Simultaneous reqs: exactly one ack per grant; the others wait. Starvation-free: any held req wins within NUM_REQ grants.
//  - req[i] still high right after its ack counts as a new byte. Requesters drop req on ack.
//  - busy = (state != IDLE), registered.
//  - Pointer wrap: search from last+1 wraps NUM_REQ-1 -> 0.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined:
//  - 16-bit wd_cnt clears on entry to BUSY and increments each BUSY cycle.
//  - At wd_cnt==TIMEOUT_CYC-1 with tx_done=0: go to IDLE and pulse timeout_err for 1 cycle. The byte is not retried.
//  - tx_done=1 in the same cycle wins: normal completion, no err.
//  UART_ARB_TIMEOUT_EN undefined: BUSY waits for tx_done forever; timeout_err tied 0; no counter.
// STRUCTURE
//  Package uart_arb_pkg:
//  - typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_BUSY} arb_state_t
//  - localparam UART_FRAME_CYC = 26040
//  Sub-module uart_rr_pick (combinational):
//  - Inputs: req, last. Outputs: winner, any.
//  - Behaviour: rotate, priority-encode, unrotate.
//  Top: state register, data/grant registers, watchdog.
// TESTING
//  Bench: UART_tx instance plus a fast tx_done model; run with and without UART_ARB_TIMEOUT_EN.
//  1. Reset, then req=4'b0001, data0=8'hA5
//     -> trmt and req_ack=0001 one cycle later, tx_data=A5, grant_id=0, one frame on TX.
//  2. req=4'b1111 held, each requester dropping its req on its own ack
//     -> grant order 0,1,2,3; 4 frames; never two acks in one cycle.
//  3. Stale tx_done=1 before grant, req1=8'h3C
//     -> stays in BUSY through the full frame; no early return to IDLE.
//  4. Requester 2 re-asserts req in the cycle tx_done rises, with req3 also pending
//     -> after last=2 the next grant goes to 3 and a second trmt follows 2 cycles after tx_done.
//  5. rst_n=0 mid-BUSY
//     -> next cycle state IDLE, busy=0, trmt=0, tx_data=00; next grant goes to requester 0.
//  6. Macro on, TIMEOUT_CYC=100, tx_done held 0
//     -> timeout_err pulses 100 cycles after BUSY entry; busy=0; pending req granted next.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg : shared types and constants for the UART transmit arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_BUSY = 2'd2
  } arb_state_t;

  // One 10-bit frame at 19200 baud on the 50 MHz system clock.
  localparam int UART_FRAME_CYC = 26040;

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick : combinational round-robin picker (rotate, encode, unrotate)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any
);
  import uart_arb_pkg::*;

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]       w_start;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDW-1:0]       w_offs;
  logic [IDW:0]         w_sum;
  logic [IDW:0]         w_wrap;

  always_comb begin
    w_start = (last == IDW'(NUM_REQ - 1)) ? '0 : last + 1'b1;
    // Doubling the vector makes the rotation correct for non power-of-two counts.
    w_dbl   = {req, req} >> w_start;
    w_rot   = w_dbl[NUM_REQ-1:0];
    w_offs  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_offs = IDW'(j);
    end
    w_sum  = {1'b0, w_start} + {1'b0, w_offs};
    w_wrap = w_sum - (IDW+1)'(NUM_REQ);
    winner = (w_sum >= (IDW+1)'(NUM_REQ)) ? w_wrap[IDW-1:0] : w_sum[IDW-1:0];
    any    = |req;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter : round-robin sharing of one UART transmitter; optional
// BUSY watchdog enabled by UART_ARB_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 32768
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       trmt,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);
  import uart_arb_pkg::*;

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [7:0]         r_data;
  logic [IDW-1:0]     r_grant;
  logic [IDW-1:0]     r_last;
  logic [NUM_REQ-1:0] r_ack;
  logic [IDW-1:0]     w_winner;
  logic               w_any;
  logic               w_timeout;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .last   (r_last),
    .winner (w_winner),
    .any    (w_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] C_WD_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_wd;
  logic        r_err;

  assign w_timeout = (r_state == ARB_BUSY) && (r_wd == C_WD_LAST) && !tx_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state == ARB_SEND) r_wd <= '0;
      else if (r_state == ARB_BUSY) r_wd <= r_wd + 16'd1;
    end
  end

  assign timeout_err = r_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_next;
  end

  // tx_done is only looked at in BUSY, so a level left over from the previous frame is harmless.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: if (w_any) w_next = ARB_SEND;
      ARB_SEND: w_next = ARB_BUSY;
      ARB_BUSY: if (tx_done || w_timeout) w_next = ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= 8'h00;
      r_grant <= '0;
      r_last  <= IDW'(NUM_REQ - 1);
      r_ack   <= '0;
    end else begin
      r_ack <= '0;
      if (r_state == ARB_IDLE && w_any) begin
        r_data  <= req_data[{w_winner, 3'b000} +: 8];
        r_grant <= w_winner;
        r_last  <= w_winner;
        r_ack   <= NUM_REQ'(1) << w_winner;
      end
    end
  end

  always_comb begin
    trmt     = (r_state == ARB_SEND);
    busy     = (r_state != ARB_IDLE);
    req_ack  = r_ack;
    tx_data  = r_data;
    grant_id = r_grant;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter : scoreboard bench with a fast tx_done model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TO_CYC  = 100;
  localparam int FRAME   = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // UART stand-in: clears tx_done on trmt, raises it FRAME cycles later unless hung.
  logic stale_done = 1'b1;
  logic hang = 1'b0;
  int   frame_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      tx_done   <= stale_done;
      frame_cnt <= 0;
    end else if (trmt) begin
      tx_done   <= 1'b0;
      frame_cnt <= hang ? 0 : FRAME;
    end else if (frame_cnt != 0) begin
      frame_cnt <= frame_cnt - 1;
      if (frame_cnt == 1) tx_done <= 1'b1;
    end
  end

  logic [9:0] exp_q[$];
  logic [9:0] e;
  logic [3:0] oh;
  int  busy_len = 0;
  int  n_trmt = 0;
  bit  chk_len = 0;
  bit  expect_err = 0;

  always @(negedge clk) begin
    if (busy) busy_len++;
    else begin
      if (busy_len != 0 && chk_len) check("busy_len", busy_len, FRAME + 2);
      busy_len = 0;
    end
    if (trmt) begin
      n_trmt++;
      if (exp_q.size() == 0) check("unexpected_trmt", 1, 0);
      else begin
        e  = exp_q.pop_front();
        oh = 4'b0001 << e[9:8];
        check("grant_id", grant_id, e[9:8]);
        check("tx_data", tx_data, e[7:0]);
        check("req_ack", req_ack, oh);
      end
    end else if (req_ack != 4'b0000) check("ack_without_trmt", req_ack, 0);
    if (timeout_err && !expect_err) check("spurious_timeout_err", timeout_err, 0);
  end

  task automatic tick();
    @(negedge clk);
    req = req & ~req_ack;
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_q.push_back({2'(id), d});
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k;
    for (k = 0; k < max; k++) begin
      tick();
      if (!busy && req == 4'b0000 && exp_q.size() == 0) break;
    end
    check(tag, k < max, 1);
    tick();
  endtask

  task automatic do_reset();
    chk_len = 0;
    req = 4'b0000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_len = 1;
  endtask

  initial begin
    int base;
    int k;
    rst_n = 1'b0;
    req = 4'b0000;
    req_data = 32'h0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_trmt", trmt, 0);
    check("rst_ack", req_ack, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_grant_id", grant_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    tick();
    chk_len = 1;

    // 1: single request, one-cycle latency to trmt/ack
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    push(0, 8'hA5);
    tick();
    check("t1_trmt_latency", trmt, 1);
    wait_idle("t1_idle", 200);

    // 2: all four requesting from reset; expect order 0,1,2,3
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    base = n_trmt;
    req = 4'b1111;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44);
    wait_idle("t2_idle", 500);
    check("t2_frames", n_trmt - base, 4);

    // 3: tx_done still high from the last frame when requester 1 is granted
    req_data[15:8] = 8'h3C;
    req = 4'b0010;
    push(1, 8'h3C);
    repeat (4) tick();
    check("t3_busy_held", busy, 1);
    wait_idle("t3_idle", 200);

    // 4: requester 2 re-requests as tx_done rises while 3 is pending
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    push(2, 8'h5A);
    repeat (3) tick();
    req_data[31:24] = 8'hC3;
    req[3] = 1'b1;
    push(3, 8'hC3);
    for (k = 0; k < 100; k++) begin
      tick();
      if (busy && !trmt && tx_done) break;
    end
    check("t4_done_seen", k < 100, 1);
    req_data[23:16] = 8'h77;
    req[2] = 1'b1;
    push(2, 8'h77);
    tick();
    check("t4_gap_idle", trmt, 0);
    tick();
    check("t4_trmt_2_after_done", trmt, 1);
    check("t4_next_is_3", grant_id, 3);
    wait_idle("t4_idle", 300);

    // 5: reset in the middle of a frame
    req_data[7:0] = 8'hE1;
    req = 4'b0001;
    push(0, 8'hE1);
    repeat (6) tick();
    check("t5_busy_before", busy, 1);
    chk_len = 0;
    req = 4'b0000;
    rst_n = 1'b0;
    tick();
    check("t5_busy", busy, 0);
    check("t5_trmt", trmt, 0);
    check("t5_tx_data", tx_data, 8'h00);
    check("t5_grant_id", grant_id, 0);
    rst_n = 1'b1;
    tick();
    chk_len = 1;
    req_data = {8'h99, 8'h00, 8'h00, 8'h11};
    req = 4'b1001;
    push(0, 8'h11); push(3, 8'h99);
    wait_idle("t5_idle", 300);

    // 6: UART never finishes
    chk_len = 0;
    hang = 1'b1;
    req_data[23:16] = 8'hD2;
    req = 4'b0100;
    push(2, 8'hD2);
    for (k = 0; k < 10; k++) begin
      tick();
      if (trmt) break;
    end
    check("t6_trmt_seen", k < 10, 1);
`ifdef UART_ARB_TIMEOUT_EN
    expect_err = 1;
    tick();
    req_data[15:8] = 8'hB1;
    req[1] = 1'b1;
    push(1, 8'hB1);
    for (k = 2; k < 300; k++) begin
      tick();
      if (timeout_err) break;
    end
    check("t6_err_cycle", k, 101);
    check("t6_busy_at_err", busy, 0);
    hang = 1'b0;
    tick();
    expect_err = 0;
    check("t6_err_one_cycle", timeout_err, 0);
    check("t6_pending_trmt", trmt, 1);
    chk_len = 1;
    wait_idle("t6_idle", 300);
`else
    repeat (300) tick();
    check("t6_still_busy", busy, 1);
    check("t6_no_err", timeout_err, 0);
    hang = 1'b0;
    do_reset();
`endif

    check("q_empty_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
